// File: rtl/pll_rst_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
// Optional lock filter is enabled with the LOCK_FILTER_EN macro.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_FILTER_CYCLES = 64;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences downstream reset release after PLL lock and tracks lock losses.
// Define LOCK_FILTER_EN to require FILTER_CYCLES of stable lock before HOLD.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_locked,
    input  logic             clr_status,
    output logic             sys_rst,
    output logic             ready,
    output logic             lost_sticky,
    output logic [CNT_W-1:0] loss_count
);

    // One counter serves both FILTER and HOLD, so it is sized for the larger.
    localparam int CTR_W = $clog2(max_int(HOLD_CYCLES, FILTER_CYCLES) + 1);
    localparam logic [CTR_W-1:0] HOLD_LAST = CTR_W'(HOLD_CYCLES - 1);
`ifdef LOCK_FILTER_EN
    localparam logic [CTR_W-1:0] FILTER_LAST = CTR_W'(FILTER_CYCLES - 1);
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             lock_s;
    pll_state_t       state;
    pll_state_t       next_state;
    logic [CTR_W-1:0] ctr;
    logic             ctr_inc;
    logic             loss_evt;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_LOCK;
        end else begin
            state <= next_state;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        next_state = state;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
`ifdef LOCK_FILTER_EN
                    next_state = FILTER;
`else
                    next_state = HOLD;
`endif
                end
            end
`ifdef LOCK_FILTER_EN
            FILTER: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end else if (ctr == FILTER_LAST) begin
                    next_state = HOLD;
                end
            end
`endif
            HOLD: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end else if (ctr == HOLD_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end
            end
            default: next_state = WAIT_LOCK;
        endcase
    end

    // ---- output / datapath control ----
    // The counter only advances while a counting state holds; any transition clears it.
    always_comb begin
        ctr_inc  = 1'b0;
        loss_evt = 1'b0;
        case (state)
            FILTER, HOLD: ctr_inc  = (next_state == state);
            RUN:          loss_evt = !lock_s;
            default:      ctr_inc  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr <= '0;
        end else if (ctr_inc) begin
            ctr <= ctr + 1'b1;
        end else begin
            ctr <= '0;
        end
    end

    // A loss in the same cycle as clr_status wins and starts the count afresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            lost_sticky <= 1'b0;
            loss_count  <= '0;
        end else if (loss_evt) begin
            lost_sticky <= 1'b1;
            if (clr_status) begin
                loss_count <= CNT_W'(1);
            end else if (loss_count != CNT_MAX) begin
                loss_count <= loss_count + 1'b1;
            end
        end else if (clr_status) begin
            lost_sticky <= 1'b0;
            loss_count  <= '0;
        end
    end

    // sys_rst/ready follow the state with one register of delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            sys_rst <= (state != RUN);
            ready   <= (state == RUN);
        end
    end

endmodule
